// File: rtl/period_tone_gen_pkg.sv
// period_tone_gen_pkg: shared types and defaults for the period path
package period_tone_gen_pkg;
  localparam int PT_WIDTH = 24;
  localparam int MIN_PERIOD_DEF = 2;
  typedef logic [PT_WIDTH-1:0] period_t;
  localparam period_t DEFAULT_PERIOD_DEF = 24'd50000;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/period_tone_gen_downcounter.sv
// period_downcounter: loadable down-counter with a zero flag
module period_downcounter import period_tone_gen_pkg::*; #(
  parameter int WIDTH = PT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  assign zero = count == '0;
  // load takes priority over decrement
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (en) count <= count - WIDTH'(1);
endmodule

// File: rtl/period_tone_gen.sv
// period_tone_gen: double-buffered square-wave tone generator with edge strobe
module period_tone_gen import period_tone_gen_pkg::*; #(
  parameter int                WIDTH          = PT_WIDTH,
  parameter int                MIN_PERIOD     = MIN_PERIOD_DEF,
  parameter logic [WIDTH-1:0]  DEFAULT_PERIOD = WIDTH'(DEFAULT_PERIOD_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic             period_load,
  output logic             wave,
  output logic             edge_stb,
  output logic             period_ack,
  output logic [WIDTH-1:0] active_period,
  output logic             running
);
  state_t state;
  logic [WIDTH-1:0] shadow, count, cnt_val;
  logic pending, zero, cnt_load, cnt_en;
  // counter reload on RUN entry and at each boundary, cleared when dropping to IDLE
  always_comb begin
    cnt_load = (state == IDLE) ? enable : (!enable || zero);
    cnt_en = state == RUN && enable && count != '0;
    cnt_val = (state == RUN && !enable) ? '0 : ((state == IDLE || pending) ? shadow : active_period) - WIDTH'(1);
  end
  period_downcounter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(cnt_load),
    .load_value(cnt_val),
    .en(cnt_en),
    .count(count),
    .zero(zero)
  );
  // FSM, shadow register and registered outputs; a load in the same cycle overrides the pending clear
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wave <= 1'b0;
      edge_stb <= 1'b0;
      period_ack <= 1'b0;
      running <= 1'b0;
      active_period <= DEFAULT_PERIOD;
      shadow <= DEFAULT_PERIOD;
      pending <= 1'b0;
    end else begin
      edge_stb <= 1'b0;
      period_ack <= 1'b0;
      if (state == IDLE) begin
        if (enable) begin
          state <= RUN;
          running <= 1'b1;
          active_period <= shadow;
          period_ack <= pending;
          pending <= 1'b0;
        end
      end else if (!enable) begin
        state <= IDLE;
        running <= 1'b0;
        wave <= 1'b0;
      end else if (zero) begin
        wave <= ~wave;
        edge_stb <= 1'b1;
        if (pending) begin
          active_period <= shadow;
          period_ack <= 1'b1;
          pending <= 1'b0;
        end
      end
      if (period_load) begin
        shadow <= (period < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : period;
        pending <= 1'b1;
      end
    end
endmodule

// File: tb/tb_period_tone_gen.sv
// tb_period_tone_gen: table-driven, directed and randomized checks against an event-time model
module tb_period_tone_gen;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, period_load = 1'b0;
  logic [23:0] period = '0;
  logic wave, edge_stb, period_ack, running;
  logic [23:0] active_period;
  int total = 0, bad = 0;
  longint m_cyc = 0, m_next_edge = 0;
  logic m_run, m_wave, m_stb, m_ack, m_pend;
  logic [23:0] m_active, m_shadow;

  period_tone_gen dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period(period),
    .period_load(period_load),
    .wave(wave),
    .edge_stb(edge_stb),
    .period_ack(period_ack),
    .active_period(active_period),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, ld;
    logic [23:0] per;
    logic w, stb, ack, run;
    logic [23:0] act;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // edge-time model: each half-period is scheduled as an absolute cycle number
  task automatic model();
    m_cyc++;
    if (reset) begin
      m_run = 0; m_wave = 0; m_stb = 0; m_ack = 0; m_pend = 0;
      m_active = 24'd50000; m_shadow = 24'd50000;
    end else begin
      m_stb = 0; m_ack = 0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_active = m_shadow; m_ack = m_pend; m_pend = 0;
          m_next_edge = m_cyc + m_active;
        end
      end else if (!enable) begin
        m_run = 0; m_wave = 0;
      end else if (m_cyc == m_next_edge) begin
        m_wave = !m_wave; m_stb = 1;
        if (m_pend) begin m_active = m_shadow; m_ack = 1; m_pend = 0; end
        m_next_edge = m_cyc + m_active;
      end
      if (period_load) begin
        m_shadow = (period < 24'd2) ? 24'd2 : period;
        m_pend = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("wave", 32'(wave), 32'(m_wave));
    chk("edge_stb", 32'(edge_stb), 32'(m_stb));
    chk("period_ack", 32'(period_ack), 32'(m_ack));
    chk("running", 32'(running), 32'(m_run));
    chk("active_period", 32'(active_period), 32'(m_active));
  endtask

  task automatic wait_edge(output int gap);
    gap = 0;
    do begin tick(); gap++; end while (!edge_stb && gap < 100);
    if (gap >= 100) chk("edge_timeout", 32'(gap), 32'd0);
  endtask

  task automatic wait_pre_boundary();
    int n = 0;
    while (m_next_edge != m_cyc + 1 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("boundary_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int gap;
    vecs[0] = '{0, 1, 24'd4, 0, 0, 0, 0, 24'd50000};
    vecs[1] = '{1, 0, 24'd0, 0, 0, 1, 1, 24'd4};
    for (int i = 2; i < 5; i++) vecs[i] = '{1, 0, 24'd0, 0, 0, 0, 1, 24'd4};
    vecs[5] = '{1, 0, 24'd0, 1, 1, 0, 1, 24'd4};
    for (int i = 6; i < 9; i++) vecs[i] = '{1, 0, 24'd0, 1, 0, 0, 1, 24'd4};
    vecs[9] = '{1, 0, 24'd0, 0, 1, 0, 1, 24'd4};
    vecs[10] = '{1, 0, 24'd0, 0, 0, 0, 1, 24'd4};
    vecs[11] = '{1, 1, 24'd6, 0, 0, 0, 1, 24'd4};
    vecs[12] = '{1, 0, 24'd0, 0, 0, 0, 1, 24'd4};
    vecs[13] = '{1, 0, 24'd0, 1, 1, 1, 1, 24'd6};
    for (int i = 14; i < 19; i++) vecs[i] = '{1, 0, 24'd0, 1, 0, 0, 1, 24'd6};
    vecs[19] = '{1, 0, 24'd0, 0, 1, 0, 1, 24'd6};

    #1;
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_wave", 32'(wave), 32'd0);
    chk("idle_active", 32'(active_period), 32'd50000);

    foreach (vecs[i]) begin
      enable = vecs[i].en; period_load = vecs[i].ld; period = vecs[i].per;
      tick();
      chk("vec_wave", 32'(wave), 32'(vecs[i].w));
      chk("vec_stb", 32'(edge_stb), 32'(vecs[i].stb));
      chk("vec_ack", 32'(period_ack), 32'(vecs[i].ack));
      chk("vec_run", 32'(running), 32'(vecs[i].run));
      chk("vec_active", 32'(active_period), 32'(vecs[i].act));
    end
    period_load = 0;

    period_load = 1; period = 24'd0; tick();
    period = 24'd1; tick();
    period_load = 0;
    wait_edge(gap);
    chk("clamp_ack", 32'(period_ack), 32'd1);
    chk("clamp_active", 32'(active_period), 32'd2);
    wait_edge(gap);
    chk("clamp_gap", 32'(gap), 32'd2);
    wait_edge(gap);
    chk("clamp_gap2", 32'(gap), 32'd2);

    period_load = 1; period = 24'd3; tick();
    period_load = 0;
    wait_pre_boundary();
    period_load = 1; period = 24'd7; tick();
    period_load = 0;
    chk("bnd_stb", 32'(edge_stb), 32'd1);
    chk("bnd_ack_old", 32'(period_ack), 32'd1);
    chk("bnd_active_old", 32'(active_period), 32'd3);
    wait_edge(gap);
    chk("bnd_gap_old", 32'(gap), 32'd3);
    chk("bnd_ack_new", 32'(period_ack), 32'd1);
    chk("bnd_active_new", 32'(active_period), 32'd7);

    tick(); tick();
    enable = 0; tick();
    chk("drop_wave", 32'(wave), 32'd0);
    chk("drop_stb", 32'(edge_stb), 32'd0);
    chk("drop_run", 32'(running), 32'd0);
    enable = 1; tick(); tick(); tick();
    period_load = 1; period = 24'd9; tick();
    period_load = 0;
    reset = 1; tick();
    chk("rst_wave", 32'(wave), 32'd0);
    chk("rst_stb", 32'(edge_stb), 32'd0);
    chk("rst_ack", 32'(period_ack), 32'd0);
    chk("rst_active", 32'(active_period), 32'd50000);
    reset = 0; tick();
    chk("rst_entry_ack", 32'(period_ack), 32'd0);
    chk("rst_entry_active", 32'(active_period), 32'd50000);
    reset = 1; tick();
    reset = 0;

    for (int i = 0; i < 3000; i++) begin
      enable = $urandom_range(0, 19) != 0;
      period_load = $urandom_range(0, 9) == 0;
      period = 24'($urandom_range(0, 12));
      reset = $urandom_range(0, 499) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
